sar_search: RTL

//  Successive-approximation search controller: the initiating side of the eq/lt/gt

---
 rtl/sar_search_pkg.sv | 37 +++
 rtl/sar_search_if.sv | 52 +++++
 rtl/sar_search.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sar_search_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_pkg
//  Description : Shared definitions for the successive-approximation search
//                controller: state encodings and the comparator flag check
//                that every eq/lt/gt compare-interface block can reuse.
//  Revision    : 1.0  initial release
// ============================================================================
package sar_search_pkg;

    // Controller state encoding (2-bit, fixed)
    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_TEST   = 2'd1;
    localparam state_t S_VERIFY = 2'd2;
    localparam state_t S_DONE   = 2'd3;

    // Width of the bit-position counter for a W-bit search. A 1-bit search
    // still needs a 1-bit counter so the register never collapses to zero width.
    function automatic int k_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    // A well-behaved magnitude comparator asserts exactly one of eq/lt/gt.
    // Anything else (none set, or two or more set) is a comparator fault.
    function automatic logic flags_onehot(input logic eq, input logic lt, input logic gt);
        logic r_ok;
        case ({eq, lt, gt})
            3'b100, 3'b010, 3'b001: r_ok = 1'b1;
            default:                r_ok = 1'b0;
        endcase
        return r_ok;
    endfunction

endpackage : sar_search_pkg
`default_nettype wire

// File: rtl/sar_search_if.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search_if
//  Description : Handshake and compare-interface bundle between the search
//                controller (master) and its user / comparator (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface sar_search_if #(
    parameter int W = 4
) ();

    logic         start;
    logic         cmp_eq;
    logic         cmp_lt;
    logic         cmp_gt;
    logic [W-1:0] trial;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         found;
    logic         err;

    // Controller side: drives the trial value and reports status
    modport master (
        input  start,
        input  cmp_eq,
        input  cmp_lt,
        input  cmp_gt,
        output trial,
        output busy,
        output done,
        output result,
        output found,
        output err
    );

    // Requester / comparator side
    modport slave (
        output start,
        output cmp_eq,
        output cmp_lt,
        output cmp_gt,
        input  trial,
        input  busy,
        input  done,
        input  result,
        input  found,
        input  err
    );

endinterface : sar_search_if
`default_nettype wire

// File: rtl/sar_search.sv
`default_nettype none
// ============================================================================
//  Module      : sar_search
//  Description : MSB-first binary search against an external combinational
//                magnitude comparator. Recovers the comparator's x operand by
//                driving trial values and reading back eq/lt/gt; exits early
//                on eq and flags non-one-hot comparator responses.
//  Revision    : 1.0  initial release
// ============================================================================
module sar_search
    import sar_search_pkg::*;
#(
    parameter int W = 4
) (
    input  wire logic      clk,
    input  wire logic      rst_n,
    sar_search_if.master   bus
);

    localparam int           KW     = k_width(W);
    localparam logic [KW-1:0] C_KMAX = KW'(W - 1);
    localparam logic [KW-1:0] C_KONE = KW'(1);
    localparam logic [W-1:0]  C_TOP  = W'(1) << (W - 1);

    state_t        r_state;
    state_t        w_next_state;
    logic [W-1:0]  r_trial;
    logic [KW-1:0] r_k;
    logic [W-1:0]  r_result;
    logic          r_found;
    logic          r_err;

    logic          w_onehot;
    logic [W-1:0]  w_trial_kept;
    logic [W-1:0]  w_trial_next;
    logic          w_busy;
    logic          w_done;

    assign w_onehot = flags_onehot(bus.cmp_eq, bus.cmp_lt, bus.cmp_gt);

    // Resolve the current bit from the comparator, then arm the next lower bit
    always_comb begin
        w_trial_kept = r_trial;
        if (bus.cmp_lt) begin
            w_trial_kept[r_k] = 1'b0;
        end
        w_trial_next = w_trial_kept;
        if (r_k != '0) begin
            w_trial_next[r_k - C_KONE] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode; start is only honoured in IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next_state = S_TEST;
                end
            end
            S_TEST: begin
                if (!w_onehot || bus.cmp_eq) begin
                    w_next_state = S_DONE;
                end else if (r_k == '0) begin
                    w_next_state = S_VERIFY;
                end
            end
            S_VERIFY: begin
                w_next_state = S_DONE;
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Status outputs decoded from state; busy and done are mutually exclusive
    always_comb begin
        w_busy = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_TEST, S_VERIFY: w_busy = 1'b1;
            S_DONE:           w_done = 1'b1;
            default: begin
                w_busy = 1'b0;
                w_done = 1'b0;
            end
        endcase
    end

    // Search datapath: trial, bit pointer and the held result/flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_trial  <= '0;
            r_k      <= C_KMAX;
            r_result <= '0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_trial <= C_TOP;
                        r_k     <= C_KMAX;
                        r_found <= 1'b0;
                        r_err   <= 1'b0;
                    end else begin
                        r_trial <= '0;
                    end
                end
                S_TEST: begin
                    if (!w_onehot) begin
                        r_err    <= 1'b1;
                        r_found  <= 1'b0;
                        r_result <= r_trial;
                    end else if (bus.cmp_eq) begin
                        r_found  <= 1'b1;
                        r_result <= r_trial;
                    end else if (r_k != '0) begin
                        r_trial <= w_trial_next;
                        r_k     <= r_k - C_KONE;
                    end else begin
                        r_trial <= w_trial_kept;
                    end
                end
                S_VERIFY: begin
                    // Final trial has every bit resolved; one compare confirms it
                    if (w_onehot) begin
                        r_found  <= bus.cmp_eq;
                        r_result <= r_trial;
                    end else begin
                        r_err   <= 1'b1;
                        r_found <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_trial <= '0;
                end
                default: begin
                    r_trial <= '0;
                end
            endcase
        end
    end

    assign bus.trial  = r_trial;
    assign bus.busy   = w_busy;
    assign bus.done   = w_done;
    assign bus.result = r_result;
    assign bus.found  = r_found;
    assign bus.err    = r_err;

endmodule : sar_search
`default_nettype wire
